dma_wr_ring_ctrl: RTL
=====================

# dma_wr_ring_ctrl

Upstream command and framing stage for the AXI DataMover S2MM write wrapper. It slices a continuous sample stream into fixed-length frames and writes each frame into a ring of equally sized slots in DDR. For every frame it issues one write command (address, size, eof) to the DMA wrapper and forwards exactly that many beats with a generated `tlast`. It then waits for DMA completion before opening the next frame, and reports progress and errors to the register block.

## Interface
- `DATA_WIDTH`, 1024, stream/AXI data width in bits; equals the DMA wrapper's AXI data width.
- `WR_ADDR_WIDTH`, 32, width of `wr_addr` and `cfg_base_addr`, in AXI-beat units.
- `clk` input 1: single clock for all logic.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: run control, level-sensitive.
- `cfg_base_addr` input WR_ADDR_WIDTH: address of slot 0, in beats.
- `cfg_frame_beats` input 23: beats per frame.
- `cfg_slot_num` input 8: number of ring slots.
- `s_tvalid` input 1 / `s_tready` output 1 / `s_tdata` input DATA_WIDTH: sample stream in. No tlast.
- `m_tvalid` output 1 / `m_tready` input 1 / `m_tdata` output DATA_WIDTH / `m_tkeep` output DATA_WIDTH/8 / `m_tlast` output 1: stream to the DMA wrapper.
- `wr_addr` output WR_ADDR_WIDTH / `wr_size` output 32 / `wr_eof` output 1 / `wr_vld` output 1 / `wr_rdy` input 1 / `wr_err` input 1: command port of the DMA wrapper.
- `busy` output 1: the FSM is not in IDLE.
- `cur_slot` output 8: slot of the frame in progress, or of the next frame.
- `frame_done` output 1: one-cycle pulse on each successful frame.
- `frame_cnt` output 32: count of successful frames. Wraps at 2^32.
- `err_cnt` output 16: count of failed frames. Saturates at 0xFFFF.

## Operation
- **States:** IDLE, CMD, DATA, WAIT.
- **IDLE**
  - Leave IDLE when all of these hold: `enable`=1, `cfg_frame_beats`≠0, `cfg_slot_num`≠0, `wr_rdy`=1.
  - On leaving, latch `cfg_*` into shadow registers. Config changes take effect only at the next exit from IDLE.
  - On that first exit: slot=0, address=`cfg_base_addr`. Go to CMD.
- **CMD**
  - `wr_vld`=1, `wr_addr`=current address, `wr_size`=frame_beats zero-extended, `wr_eof`=1.
  - Hold until the cycle where `wr_vld`&`wr_rdy`=1, then go to DATA.
- **DATA**
  - Stream passthrough: `m_tvalid`=`s_tvalid`, `s_tready`=`m_tready`, `m_tdata`=`s_tdata`.
  - The beat counter increments on each `m_tvalid`&`m_tready`.
  - `m_tlast`=1 when beat count = frame_beats−1. That beat's transfer moves to WAIT and clears the counter.
- **WAIT**
  - `s_tready`=0, `m_tvalid`=0. Wait for `wr_rdy`=1.
  - In that same cycle, sample `wr_err`:
    - `wr_err`=0 (success): pulse `frame_done`, increment `frame_cnt`, advance the slot. Slot = slot+1, wrapping to 0 after slot_num−1; address += frame_beats, reloaded with base on wrap.
    - `wr_err`=1 (failure): increment `err_cnt`. Slot and address are unchanged, so the same slot is rewritten.
  - Then go to CMD if `enable`=1, else IDLE.
- **Address arithmetic:** use a running accumulator, no multiplier. Width WR_ADDR_WIDTH; overflow wraps modulo 2^WR_ADDR_WIDTH.
- **`enable` deasserted mid-frame:** the current frame completes (CMD→DATA→WAIT) before entering IDLE. A new `enable` session restarts at slot 0.
- **Outside DATA:** `s_tready`=0, `m_tvalid`=0, `m_tlast`=0.
- `m_tkeep` = all ones, constant.

## Timing
- **Reset values:** all outputs 0 (`m_tkeep` excepted: all ones); state IDLE; counters 0.
- **Reset assertion:** asynchronous, takes effect immediately, including mid-frame. No partial-frame recovery; the DMA wrapper is reset in the same domain.
- **`wr_vld` timing:** rises the cycle after the IDLE exit condition, or the cycle after the WAIT exit.
- **DATA entry:** one cycle after the command handshake; the first data beat can be accepted in that cycle.
- **Command outputs:** `wr_addr`, `wr_size` and `wr_eof` are registered and stable while `wr_vld`=1.
- **Stream path:** combinational (zero latency, no buffer).
- **Status outputs:** `frame_done`, `frame_cnt` and `err_cnt` update the cycle after the WAIT exit. `cur_slot` updates in that same cycle.
- **`wr_rdy` in WAIT:** the wrapper drops `wr_rdy` the cycle after the handshake, and DATA lasts at least one cycle. `wr_rdy`=1 in WAIT therefore always means completion, with `wr_err` valid in that cycle.
- **frame_beats=1:** the single beat carries `m_tlast`=1.
- **Simultaneous `enable` fall with the WAIT exit:** go to IDLE; the frame is still counted.

## Test plan
- Base=0x100, beats=4, slots=3, continuous valid, `wr_rdy` returning 5 cycles after the last beat, no error.
  - Expect `wr_addr` sequence 0x100, 0x104, 0x108, 0x100 and `cur_slot` 0,1,2,0.
  - Expect `m_tlast` on every 4th beat and `frame_cnt`=4 after four frames.
- Beats=1, slots=1: every beat has `m_tlast`=1; `wr_addr` is always the base; `wr_size`=1.
- `wr_err`=1 on frame 2 (slot 1): `err_cnt`=1, no `frame_done` pulse. The next command targets slot 1 again at the same address; `frame_cnt` is unaffected.
- Random `m_tready`/`s_tvalid` backpressure with beats=16:
  - Exactly 16 beats per command, data unchanged and in order.
  - No beats pass in CMD/WAIT.
- `enable` dropped during DATA of frame 1: frame 1 completes, FSM goes to IDLE, `busy`=0.
  - Change config while idle, then re-enable.
  - First address = new base, slot 0, new size.
- `rst_n` asserted mid-DATA: all outputs return to 0 immediately. After release with `enable`=1, the first command is slot 0.
  - `cfg_frame_beats`=0 with `enable`=1 keeps the block in IDLE, with `wr_vld` never asserted.

Source files
------------

// File: rtl/dma_wr_ring_ctrl.sv
// dma_wr_ring_ctrl: frames a continuous sample stream into fixed-length
// frames and writes each frame to the next slot of a DDR ring through the
// DataMover S2MM command/stream ports. One command per frame, generated tlast,
// completion/error tracking and progress counters for the register block.
module dma_wr_ring_ctrl #(
    parameter int DATA_WIDTH    = 1024,
    parameter int WR_ADDR_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [WR_ADDR_WIDTH-1:0]   cfg_base_addr,
    input  logic [22:0]                cfg_frame_beats,
    input  logic [7:0]                 cfg_slot_num,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [DATA_WIDTH-1:0]      s_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [DATA_WIDTH-1:0]      m_tdata,
    output logic [DATA_WIDTH/8-1:0]    m_tkeep,
    output logic                       m_tlast,
    output logic [WR_ADDR_WIDTH-1:0]   wr_addr,
    output logic [31:0]                wr_size,
    output logic                       wr_eof,
    output logic                       wr_vld,
    input  logic                       wr_rdy,
    input  logic                       wr_err,
    output logic                       busy,
    output logic [7:0]                 cur_slot,
    output logic                       frame_done,
    output logic [31:0]                frame_cnt,
    output logic [15:0]                err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_WAIT
    } state_t;

    state_t state, state_nxt;

    // Shadow copies of the configuration, frozen for a whole enable session
    logic [WR_ADDR_WIDTH-1:0] base_sh;
    logic [22:0]              beats_sh;
    logic [7:0]               slots_sh;

    // Running slot address (accumulator, no multiplier) and slot index
    logic [WR_ADDR_WIDTH-1:0] addr;
    logic [7:0]               slot;
    logic [22:0]              beat_cnt;

    logic start_ok;
    logic in_data;
    logic beat_fire;
    logic last_beat;
    logic slot_wrap;

    // Error counter saturates instead of wrapping so software never sees it roll back
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign start_ok  = enable && (cfg_frame_beats != 23'd0) && (cfg_slot_num != 8'd0) && wr_rdy;
    assign in_data   = (state == ST_DATA);
    assign beat_fire = in_data && s_tvalid && m_tready;
    assign last_beat = (beat_cnt == beats_sh - 23'd1);
    assign slot_wrap = (slot == slots_sh - 8'd1);

    // Stream passthrough is purely combinational and gated to the DATA state
    assign m_tvalid = in_data && s_tvalid;
    assign s_tready = in_data && m_tready;
    assign m_tlast  = in_data && last_beat;
    assign m_tdata  = in_data ? s_tdata : '0;
    assign m_tkeep  = '1;

    // Command fields come straight from registers, so they hold while wr_vld is up
    assign wr_vld   = (state == ST_CMD);
    assign wr_eof   = (state == ST_CMD);
    assign wr_addr  = addr;
    assign wr_size  = {9'd0, beats_sh};

    assign busy     = (state != ST_IDLE);
    assign cur_slot = slot;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_ok)              state_nxt = ST_CMD;
            ST_CMD:  if (wr_rdy)                state_nxt = ST_DATA;
            ST_DATA: if (beat_fire && last_beat) state_nxt = ST_WAIT;
            ST_WAIT: if (wr_rdy)                state_nxt = enable ? ST_CMD : ST_IDLE;
            default:                            state_nxt = ST_IDLE;
        endcase
    end

    // Config shadowing, slot/address advance, beat counting and status counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_sh    <= '0;
            beats_sh   <= '0;
            slots_sh   <= '0;
            addr       <= '0;
            slot       <= '0;
            beat_cnt   <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        base_sh  <= cfg_base_addr;
                        beats_sh <= cfg_frame_beats;
                        slots_sh <= cfg_slot_num;
                        addr     <= cfg_base_addr;
                        slot     <= 8'd0;
                        beat_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (beat_fire) begin
                        beat_cnt <= last_beat ? 23'd0 : beat_cnt + 23'd1;
                    end
                end
                ST_WAIT: begin
                    if (wr_rdy) begin
                        if (!wr_err) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 32'd1;
                            if (slot_wrap) begin
                                slot <= 8'd0;
                                addr <= base_sh;
                            end else begin
                                slot <= slot + 8'd1;
                                addr <= addr + WR_ADDR_WIDTH'(beats_sh);
                            end
                        end else begin
                            // Failed frame: keep slot and address so the same slot is rewritten
                            err_cnt <= sat_inc16(err_cnt);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
